// File: rtl/uart_rx_axis_packer_if.sv
// AXI4-Stream beat channel carrying packed UART bytes out of uart_rx_axis_packer.
interface uart_rx_axis_packer_if #(
    parameter int W = 512
) ();
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/uart_rx_axis_packer.sv
// Packs UART bytes little-endian into AXI4-Stream beats; tlast on EOT byte or done_i rising edge.
// Optional idle-timeout partial flush is enabled by defining UART_PACK_TIMEOUT_EN.
//
//  state  | meaning
//  S_FILL | accumulator accepting bytes into lane idx
//  S_HOLD | accumulator full, output register busy; incoming bytes are dropped
module uart_rx_axis_packer #(
    parameter int         C_AXIS_TDATA_WIDTH = 512,
    parameter logic [7:0] C_EOT_BYTE         = 8'h04,
    parameter int         C_TIMEOUT_CYCLES   = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    input  logic                  done_i,
    uart_rx_axis_packer_if.master m_axis,
    output logic                  overflow_o,
    output logic [31:0]           beat_count_o
);
    localparam int N  = C_AXIS_TDATA_WIDTH / 8;
    localparam int IW = $clog2(N + 1);

    if ((C_AXIS_TDATA_WIDTH % 8) != 0 || C_AXIS_TDATA_WIDTH < 16 ||
        C_AXIS_TDATA_WIDTH > 512 || C_TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_rx_axis_packer: illegal parameter value");
    end

    typedef enum logic {S_FILL, S_HOLD} state_t;

    state_t                        state, state_nxt;
    logic [C_AXIS_TDATA_WIDTH-1:0] acc, acc_nxt;
    logic [IW-1:0]                 idx, idx_nxt;
    logic [N-1:0]                  keep_nxt;
    logic                          flush_pend, flush_req, flush_now;
    logic                          done_q, done_rise;
    logic                          byte_acc, byte_drop, full_nxt;
    logic                          drain, out_free, load, to_now;

    logic                          out_valid, out_last;
    logic [C_AXIS_TDATA_WIDTH-1:0] out_data;
    logic [N-1:0]                  out_keep;

    assign drain     = out_valid & m_axis.tready;
    assign out_free  = ~out_valid | drain;
    assign byte_acc  = byte_valid_i & (state == S_FILL);
    assign byte_drop = byte_valid_i & (state == S_HOLD);
    assign done_rise = done_i & ~done_q;

    always_comb begin
        acc_nxt   = acc;
        idx_nxt   = idx;
        flush_req = done_rise;
        keep_nxt  = '0;
        if (byte_acc) begin
            for (int k = 0; k < N; k++) begin
                if (idx == IW'(k)) acc_nxt[8*k +: 8] = byte_data_i;
            end
            idx_nxt = idx + IW'(1);
            if (byte_data_i == C_EOT_BYTE) flush_req = 1'b1;
        end
        for (int k = 0; k < N; k++) keep_nxt[k] = (IW'(k) < idx_nxt);
        full_nxt  = (idx_nxt == IW'(N));
        flush_now = flush_pend | flush_req;
        load      = out_free & (full_nxt | flush_now | to_now);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: if (full_nxt && !out_free) state_nxt = S_HOLD;
            S_HOLD: if (out_free) state_nxt = S_FILL;
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FILL;
            acc        <= '0;
            idx        <= '0;
            flush_pend <= 1'b0;
            done_q     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_i;
            if (byte_drop) overflow_o <= 1'b1;
            if (load) begin
                acc        <= '0;
                idx        <= '0;
                flush_pend <= 1'b0;
            end else begin
                acc <= acc_nxt;
                idx <= idx_nxt;
                if (flush_req) flush_pend <= 1'b1;
            end
        end
    end

    // Output register only reloads when empty or handing off this cycle, keeping AXIS payload stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_keep     <= '0;
            out_last     <= 1'b0;
            beat_count_o <= '0;
        end else begin
            if (drain) beat_count_o <= beat_count_o + 32'd1;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= acc_nxt;
                out_keep  <= keep_nxt;
                out_last  <= flush_now;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef UART_PACK_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          to_pend, counting, timeout_hit;

    assign counting    = (state == S_FILL) && (idx != '0) && !byte_acc;
    assign timeout_hit = counting && (idle_cnt == TW'(C_TIMEOUT_CYCLES - 1));
    assign to_now      = to_pend | timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            to_pend  <= 1'b0;
        end else begin
            if (byte_acc || load || timeout_hit) idle_cnt <= '0;
            else if (counting)                   idle_cnt <= idle_cnt + TW'(1);
            if (load)             to_pend <= 1'b0;
            else if (timeout_hit) to_pend <= 1'b1;
        end
    end
`else
    assign to_now = 1'b0;
`endif

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tlast  = out_last;
endmodule

// File: tb/tb_uart_rx_axis_packer.sv
// Self-checking bench for uart_rx_axis_packer: byte-level model feeds a beat scoreboard.
module tb_uart_rx_axis_packer;
    localparam int         W   = 512;
    localparam int         N   = W / 8;
    localparam logic [7:0] EOT = 8'h04;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        byte_valid_i = 1'b0, done_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        overflow_o;
    logic [31:0] beat_count_o;

    uart_rx_axis_packer_if #(.W(W)) m_axis ();

    uart_rx_axis_packer #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_EOT_BYTE(EOT),
        .C_TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .byte_valid_i(byte_valid_i),
        .byte_data_i(byte_data_i),
        .done_i(done_i),
        .m_axis(m_axis),
        .overflow_o(overflow_o),
        .beat_count_o(beat_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] keep;
        logic         last;
    } beat_t;

    typedef struct {
        int         nbytes;
        logic [7:0] base;
        bit         end_eot;
        bit         end_done;
        int         exp_beats;
    } vec_t;

    beat_t        sb[$];
    beat_t        hold_b;
    bit           stall_q = 1'b0;
    int           n_cmp = 0, n_err = 0, pops = 0, m_idx = 0, m_total = 0;
    int           mode = 0;
    logic [W-1:0] m_data = '0;
    vec_t         vecs[7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] keep_of(input int n);
        logic [N-1:0] k;
        for (int i = 0; i < N; i++) k[i] = (i < n);
        return k;
    endfunction

    task automatic push_beat(input bit last);
        beat_t b;
        b.data = m_data;
        b.keep = keep_of(m_idx);
        b.last = last;
        sb.push_back(b);
        m_total++;
        m_data = '0;
        m_idx  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_data[8*m_idx +: 8] = b;
        m_idx++;
        if (b == EOT || m_idx == N) push_beat(b == EOT);
    endtask

    task automatic send_raw(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        @(posedge clk); #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        push_beat(1'b1);
        @(posedge clk); #1;
        done_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while ((sb.size() != 0 || m_axis.tvalid) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_drain_left"}, sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        byte_valid_i = 1'b0;
        done_i       = 1'b0;
        stall_q      = 1'b0;
        sb.delete();
        m_data  = '0;
        m_idx   = 0;
        m_total = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis.tvalid, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_beat_count", beat_count_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0:       m_axis.tready = 1'b1;
                1:       m_axis.tready = 1'($urandom_range(0, 1));
                default: m_axis.tready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_q) begin
                chk("stall_tvalid", m_axis.tvalid, 1);
                chk("stall_tdata", m_axis.tdata, hold_b.data);
                chk("stall_tkeep_tlast", {m_axis.tkeep, m_axis.tlast}, {hold_b.keep, hold_b.last});
            end
            if (m_axis.tvalid && m_axis.tready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got keep %0h last %0b, expected no beat",
                             m_axis.tkeep, m_axis.tlast);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_tdata", m_axis.tdata, e.data);
                    chk("beat_tkeep", m_axis.tkeep, e.keep);
                    chk("beat_tlast", m_axis.tlast, e.last);
                    pops++;
                end
            end
            stall_q     = m_axis.tvalid && !m_axis.tready;
            hold_b.data = m_axis.tdata;
            hold_b.keep = m_axis.tkeep;
            hold_b.last = m_axis.tlast;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        vecs[0] = '{64,  8'h10, 1'b0, 1'b0, 1};
        vecs[1] = '{3,   8'h41, 1'b1, 1'b0, 1};
        vecs[2] = '{63,  8'h80, 1'b1, 1'b0, 1};
        vecs[3] = '{0,   8'h00, 1'b0, 1'b1, 1};
        vecs[4] = '{130, 8'h10, 1'b0, 1'b1, 3};
        vecs[5] = '{5,   8'h20, 1'b1, 1'b0, 1};
        vecs[6] = '{10,  8'h50, 1'b0, 1'b1, 1};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            mode = i % 2;
            p0 = pops;
            for (int j = 0; j < vecs[i].nbytes; j++) send_byte(vecs[i].base + 8'(j));
            if (vecs[i].end_eot)  send_byte(EOT);
            if (vecs[i].end_done) pulse_done();
            wait_drain("vec");
            chk("vec_beats", pops - p0, vecs[i].exp_beats);
        end
        mode = 0;
        @(posedge clk); #1;
        chk("beat_count_vec", beat_count_o, m_total);

        // done_i held high: one flush only
        done_i = 1'b1;
        push_beat(1'b1);
        repeat (20) @(posedge clk);
        #1;
        wait_drain("done_held");
        done_i = 1'b0;
        @(posedge clk); #1;

        // byte and done rising edge in the same cycle: byte joins the flushed beat
        send_byte(8'hA1);
        send_byte(8'hA2);
        byte_valid_i = 1'b1;
        byte_data_i  = 8'h77;
        done_i       = 1'b1;
        m_data[8*m_idx +: 8] = 8'h77;
        m_idx++;
        push_beat(1'b1);
        @(posedge clk); #1;
        byte_valid_i = 1'b0;
        done_i       = 1'b0;
        wait_drain("byte_done");

        // flush requested while the output register is stalled
        mode = 2;
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) send_byte(8'h20 + 8'(j));
        for (int j = 0; j < 10; j++) send_byte(8'hC0 + 8'(j));
        pulse_done();
        repeat (10) @(posedge clk);
        #1;
        chk("busy_flush_no_overflow", overflow_o, 0);
        mode = 0;
        wait_drain("busy_flush");
        chk("beat_count_all", beat_count_o, m_total);

        // overflow in HOLD
        do_reset();
        mode = 2;
        @(posedge clk); #1;
        for (int j = 0; j < 200; j++) begin
            if (j < 2 * N) send_byte(8'h10 + 8'(j));
            else           send_raw(8'h10 + 8'(j));
        end
        chk("ovf_sticky", overflow_o, 1);
        chk("ovf_held_valid", m_axis.tvalid, 1);
        p0 = pops;
        mode = 0;
        wait_drain("ovf");
        chk("ovf_beats", pops - p0, 2);
        chk("ovf_still_set", overflow_o, 1);

        // reset mid-beat discards partial data
        for (int j = 0; j < 10; j++) send_raw(8'hE0 + 8'(j));
        do_reset();
        for (int j = 0; j < N; j++) send_byte(8'h90 + 8'(j));
        wait_drain("post_reset");
        chk("post_reset_count", beat_count_o, 1);

`ifdef UART_PACK_TIMEOUT_EN
        begin
            int c = 0;
            for (int j = 0; j < 5; j++) send_byte(8'h60 + 8'(j));
            push_beat(1'b0);
            while (!m_axis.tvalid && c < 52) begin
                @(negedge clk);
                c++;
            end
            chk("timeout_within_52", m_axis.tvalid, 1);
            @(posedge clk); #1;
            wait_drain("timeout");
        end
`endif

        chk("beat_count_final", beat_count_o, m_total);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
